// File: rtl/inst_trace_buffer_if.sv
// Clock type shared with the IU, plus the capture/drain bundle of the retire trace buffer.
package iu_pkg;
  typedef struct packed {
    logic clk;
  } iu_clk_type;
endpackage

// Handshake: a record moves on the read port in any cycle where rd_valid and rd_ready are both high;
// rd_valid never depends on rd_ready, and rd_ready without rd_valid has no effect.
interface inst_trace_buffer_if #(
  parameter int NTHREADLOG = 6,
  parameter int DEPTH      = 512,
  parameter int TIMEW      = 32
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = TIMEW + NTHREADLOG + 68;

  logic                  cap_valid;
  logic [NTHREADLOG-1:0] cap_tid;
  logic [31:0]           cap_pc;
  logic [31:0]           cap_inst;
  logic [3:0]            cap_flags;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DW-1:0]         rd_data;
  logic [CW-1:0]         rd_count;

  modport master (
    output cap_valid, cap_tid, cap_pc, cap_inst, cap_flags, rd_ready,
    input  rd_valid, rd_data, rd_count
  );

  modport slave (
    input  cap_valid, cap_tid, cap_pc, cap_inst, cap_flags, rd_ready,
    output rd_valid, rd_data, rd_count
  );
endinterface

// File: rtl/inst_trace_buffer.sv
// Circular retire-trace buffer: filters and captures commit records until a trigger plus
// post-trigger depth, then freezes and drains through a valid/ready read port.
module inst_trace_buffer
  import iu_pkg::*;
#(
  parameter int NTHREADLOG = 6,
  parameter int DEPTH      = 512,
  parameter int TIMEW      = 32
) (
  input  iu_clk_type                  gclk,
  input  logic                        rst,
  inst_trace_buffer_if.slave          bus,
  input  logic                        cfg_arm,
  input  logic [2**NTHREADLOG-1:0]    cfg_tid_mask,
  input  logic                        cfg_drop_replay,
  input  logic                        cfg_trig_en,
  input  logic [31:0]                 cfg_trig_pc,
  input  logic [$clog2(DEPTH):0]      cfg_post_cnt,
  output logic [1:0]                  state,
  output logic                        overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = TIMEW + NTHREADLOG + 68;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d, remain_q, remain_d;
  logic [TIMEW-1:0] ts_q;
  logic             ovf_q, ovf_d;
  logic [DW-1:0]    mem_q [DEPTH];

  logic             clk;
  logic             capturing, acc, trig, full, pop;
  logic [DW-1:0]    wr_rec;

  assign clk = gclk.clk;

  always_comb begin
    capturing = (state_q == ARMED) || (state_q == POST);
    acc  = bus.cap_valid & cfg_tid_mask[bus.cap_tid]
         & ~(cfg_drop_replay & (bus.cap_flags[3] | bus.cap_flags[2]))
         & capturing & ~cfg_arm;
    trig = (state_q == ARMED) & acc & (~cfg_trig_en | (bus.cap_pc == cfg_trig_pc));
    full = (count_q == CW'(DEPTH));
    pop  = bus.rd_valid & bus.rd_ready & ~cfg_arm;
    wr_rec = {ts_q, bus.cap_tid, bus.cap_pc, bus.cap_inst, bus.cap_flags};

    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    remain_d = remain_q;
    ovf_d    = ovf_q;

    if (cfg_arm) begin
      state_d  = ARMED;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      remain_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (acc) begin
        tail_d = tail_q + AW'(1);
        // A full buffer keeps the newest DEPTH records by dropping the oldest.
        if (full) begin
          head_d = head_q + AW'(1);
          ovf_d  = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      if (pop) begin
        head_d  = head_q + AW'(1);
        count_d = count_q - CW'(1);
      end
      case (state_q)
        ARMED: begin
          if (trig) begin
            if (cfg_post_cnt == '0) begin
              state_d = DONE;
            end else begin
              state_d  = POST;
              remain_d = cfg_post_cnt;
            end
          end
        end
        POST: begin
          if (acc) begin
            remain_d = remain_q - CW'(1);
            if (remain_q == CW'(1)) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      remain_q <= '0;
      ts_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      remain_q <= remain_d;
      ts_q     <= ts_q + TIMEW'(1);
      ovf_q    <= ovf_d;
    end
  end

  // Storage array carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (acc) mem_q[tail_q] <= wr_rec;
  end

  assign bus.rd_valid = (state_q == DONE) && (count_q != '0);
  assign bus.rd_data  = bus.rd_valid ? mem_q[head_q] : '0;
  assign bus.rd_count = count_q;
  assign state        = state_q;
  assign overflow     = ovf_q;

endmodule
